// File: rtl/xadc_drp_arbiter_if.sv
// ----------------------------------------------------------------------------
// xadc_drp_arbiter_if
// Requester-side bus of the XADC DRP arbiter. It carries the packed
// per-requester request fields and the completion/read-data return path.
// The master modport belongs to the requester cluster and the slave modport
// belongs to the arbiter.
// ----------------------------------------------------------------------------
interface xadc_drp_arbiter_if #(
  parameter int NUM_REQ = 3
);

  logic [NUM_REQ-1:0]    req_en;
  logic [NUM_REQ-1:0]    req_we;
  logic [7*NUM_REQ-1:0]  req_addr;
  logic [16*NUM_REQ-1:0] req_wdata;
  logic [NUM_REQ-1:0]    req_done;
  logic [NUM_REQ-1:0]    req_err;
  logic [15:0]           rdata;

  modport master (
    output req_en,
    output req_we,
    output req_addr,
    output req_wdata,
    input  req_done,
    input  req_err,
    input  rdata
  );

  modport slave (
    input  req_en,
    input  req_we,
    input  req_addr,
    input  req_wdata,
    output req_done,
    output req_err,
    output rdata
  );

endinterface

// File: rtl/xadc_drp_arbiter.sv
// ----------------------------------------------------------------------------
// xadc_drp_arbiter
// Round-robin arbiter that shares the single XADC DRP among NUM_REQ
// requesters. A granted access runs IDLE -> ISSUE -> (WAIT) -> DONE; DEN is
// driven for exactly the ISSUE cycle, read data is captured on DRDY and a
// one-cycle completion pulse is returned to the granted requester.
//
// Optional feature macro: XADC_DRP_TIMEOUT_EN
//   defined   : a WAIT-cycle counter aborts an access after TIMEOUT_CYCLES
//               cycles without DRDY, pulsing req_err and returning 16'hFFFF.
//   undefined : no counter, WAIT lasts until DRDY, req_err is tied low.
// ----------------------------------------------------------------------------
module xadc_drp_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  xadc_drp_arbiter_if.slave   req_bus,
  output logic                drp_en,
  output logic                drp_we,
  output logic [6:0]          drp_addr,
  output logic [15:0]         drp_din,
  input  logic                drp_rdy,
  input  logic [15:0]         drp_dout,
  output logic                busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0]     last_grant_q, last_grant_d;
  logic                 drp_en_q, drp_en_d;
  logic                 drp_we_q, drp_we_d;
  logic [6:0]           drp_addr_q, drp_addr_d;
  logic [15:0]          drp_din_q, drp_din_d;
  logic [15:0]          rdata_q, rdata_d;
  logic [NUM_REQ-1:0]   req_done_q, req_done_d;
  logic                 busy_q, busy_d;

  logic                 win_found_s;
  logic [IDX_W-1:0]     win_idx_s;

`ifdef XADC_DRP_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0]          tmo_cnt_q, tmo_cnt_d;
  logic [NUM_REQ-1:0]   req_err_q, req_err_d;
`endif

  // One-hot completion vector for the granted requester.
  function automatic logic [NUM_REQ-1:0] grant_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

  // Round-robin search: first set req_en bit starting after last_grant, wrapping.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int cand;
      cand = int'(last_grant_q) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end else begin
        cand = cand;
      end
      if (!win_found_s && req_bus.req_en[cand]) begin
        win_found_s = 1'b1;
        win_idx_s   = IDX_W'(cand);
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Next-state and registered-output logic for the access sequencer.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    drp_en_d     = 1'b0;
    drp_we_d     = drp_we_q;
    drp_addr_d   = drp_addr_q;
    drp_din_d    = drp_din_q;
    rdata_d      = rdata_q;
    req_done_d   = '0;
    busy_d       = 1'b1;
`ifdef XADC_DRP_TIMEOUT_EN
    tmo_cnt_d    = tmo_cnt_q;
    req_err_d    = '0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (win_found_s) begin
          grant_d      = win_idx_s;
          last_grant_d = win_idx_s;
          drp_we_d     = req_bus.req_we[win_idx_s];
          drp_addr_d   = req_bus.req_addr[int'(win_idx_s)*7 +: 7];
          drp_din_d    = req_bus.req_wdata[int'(win_idx_s)*16 +: 16];
          drp_en_d     = 1'b1;
          state_d      = ST_ISSUE;
        end else begin
          busy_d       = 1'b0;
        end
      end

      ST_ISSUE: begin
        // DRDY coincident with DEN short-circuits the WAIT state.
        if (drp_rdy) begin
          rdata_d    = drp_dout;
          req_done_d = grant_onehot(grant_q);
          state_d    = ST_DONE;
        end else begin
          state_d    = ST_WAIT;
`ifdef XADC_DRP_TIMEOUT_EN
          tmo_cnt_d  = 16'd0;
`endif
        end
      end

      ST_WAIT: begin
        // DRDY takes priority over the final timeout count.
        if (drp_rdy) begin
          rdata_d    = drp_dout;
          req_done_d = grant_onehot(grant_q);
          state_d    = ST_DONE;
        end
`ifdef XADC_DRP_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_LAST) begin
          rdata_d    = 16'hFFFF;
          req_done_d = grant_onehot(grant_q);
          req_err_d  = grant_onehot(grant_q);
          state_d    = ST_DONE;
        end else begin
          tmo_cnt_d  = tmo_cnt_q + 16'd1;
        end
`else
        else begin
          state_d    = ST_WAIT;
        end
`endif
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, grant bookkeeping and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      drp_en_q     <= 1'b0;
      drp_we_q     <= 1'b0;
      drp_addr_q   <= 7'd0;
      drp_din_q    <= 16'd0;
      rdata_q      <= 16'd0;
      req_done_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      drp_en_q     <= drp_en_d;
      drp_we_q     <= drp_we_d;
      drp_addr_q   <= drp_addr_d;
      drp_din_q    <= drp_din_d;
      rdata_q      <= rdata_d;
      req_done_q   <= req_done_d;
      busy_q       <= busy_d;
    end
  end

`ifdef XADC_DRP_TIMEOUT_EN
  // WAIT-cycle counter and error pulse register for the abort path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= 16'd0;
      req_err_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      req_err_q <= req_err_d;
    end
  end

  assign req_bus.req_err = req_err_q;
`else
  assign req_bus.req_err = '0;
`endif

  assign req_bus.req_done = req_done_q;
  assign req_bus.rdata    = rdata_q;
  assign drp_en           = drp_en_q;
  assign drp_we           = drp_we_q;
  assign drp_addr         = drp_addr_q;
  assign drp_din          = drp_din_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_xadc_drp_arbiter.sv
// ----------------------------------------------------------------------------
// tb_xadc_drp_arbiter
// Self-checking bench for xadc_drp_arbiter. A behavioural XADC model answers
// DEN with DRDY after a programmable latency; requesters are modelled as
// simple arrays. Expected grants come from the round-robin rule applied to
// the request vector seen in each IDLE cycle, expected read data from a
// reference copy of the XADC register file.
// ----------------------------------------------------------------------------
module tb_xadc_drp_arbiter;

  localparam int N  = 3;
  localparam int TO = 8;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        drp_en;
  logic        drp_we;
  logic [6:0]  drp_addr;
  logic [15:0] drp_din;
  logic        drp_rdy  = 1'b0;
  logic [15:0] drp_dout = 16'd0;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  // Requester model
  logic [N-1:0] r_en = '0;
  logic [N-1:0] r_we = '0;
  logic [6:0]   r_addr  [N];
  logic [15:0]  r_wdata [N];

  // XADC model
  logic [15:0] xmem    [128];
  logic [15:0] ref_mem [128];
  int          lat        = 1;
  bit          mute       = 1'b0;
  bit          inject_rdy = 1'b0;
  int          pend       = -1;
  logic [15:0] pend_data  = 16'd0;

  always #5 clk = ~clk;

  xadc_drp_arbiter_if #(.NUM_REQ(N)) bus ();

  xadc_drp_arbiter #(
    .NUM_REQ        (N),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_bus  (bus),
    .drp_en   (drp_en),
    .drp_we   (drp_we),
    .drp_addr (drp_addr),
    .drp_din  (drp_din),
    .drp_rdy  (drp_rdy),
    .drp_dout (drp_dout),
    .busy     (busy)
  );

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Round-robin rule: first requesting index after 'last', modulo N.
  function automatic int rr_pick(input logic [N-1:0] en, input int last);
    for (int k = 1; k <= N; k++) begin
      if (en[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic drive();
    bus.req_en = r_en;
    bus.req_we = r_we;
    for (int i = 0; i < N; i++) begin
      bus.req_addr[7*i +: 7]    = r_addr[i];
      bus.req_wdata[16*i +: 16] = r_wdata[i];
    end
  endtask

  // Drive current inputs, advance one clock, then update the XADC model for
  // the cycle just entered (outputs are sampled 1 ns after the edge).
  task automatic tick();
    drive();
    @(posedge clk);
    #1;
    drp_rdy  = 1'b0;
    drp_dout = 16'($urandom);
    if (rst_n && drp_en) begin
      if (drp_we) xmem[drp_addr] = drp_din;
      pend_data = xmem[drp_addr];
      if (!mute) begin
        if (lat == 0) begin
          drp_rdy  = 1'b1;
          drp_dout = pend_data;
          pend     = -1;
        end else begin
          pend = lat;
        end
      end
    end else if (pend > 0) begin
      pend = pend - 1;
      if (pend == 0) begin
        drp_rdy  = 1'b1;
        drp_dout = pend_data;
        pend     = -1;
      end
    end
    if (inject_rdy) begin
      drp_rdy    = 1'b1;
      inject_rdy = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    r_en  = '0;
    pend  = -1;
    mute  = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    for (int i = 0; i < N; i++) begin
      r_addr[i]  = 7'd0;
      r_wdata[i] = 16'd0;
    end
    for (int a = 0; a < 128; a++) begin
      xmem[a]    = 16'($urandom);
      ref_mem[a] = xmem[a];
    end
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({bus.req_done, bus.req_err, bus.rdata, drp_en, drp_we, drp_addr, drp_din, busy} !== '0)
      $display("FAIL reset_values: got done=%b err=%b rdata=%h en=%b we=%b addr=%h din=%h busy=%b, want all 0",
               bus.req_done, bus.req_err, bus.rdata, drp_en, drp_we, drp_addr, drp_din, busy);
    if ({bus.req_done, bus.req_err, bus.rdata, drp_en, drp_we, drp_addr, drp_din, busy} !== '0) failures++;
    rst_n = 1'b1;
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || drp_en !== 1'b0 || bus.req_done !== '0) begin
      failures++;
      $display("FAIL reset_idle: busy=%b en=%b done=%b, want 0/0/0", busy, drp_en, bus.req_done);
    end
  endtask

  task automatic test_single_read();
    int en_cnt, en_cyc, done_cyc;
    logic [6:0]   en_addr;
    logic         en_we;
    logic [N-1:0] done_v, err_v;
    logic [15:0]  rd;
    do_reset();
    xmem[0] = 16'hB5E0; ref_mem[0] = 16'hB5E0;
    lat = 3;
    r_we[0] = 1'b0; r_addr[0] = 7'h00; r_wdata[0] = 16'($urandom); r_en[0] = 1'b1;
    en_cnt = 0; en_cyc = -1; done_cyc = -1; en_addr = 7'h7F; en_we = 1'b1;
    done_v = '0; err_v = '0; rd = 16'd0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (drp_en === 1'b1) begin
        en_cnt++; en_cyc = c; en_addr = drp_addr; en_we = drp_we;
      end
      if (bus.req_done !== '0 && done_cyc < 0) begin
        done_cyc = c; done_v = bus.req_done; err_v = bus.req_err; rd = bus.rdata;
        r_en[0] = 1'b0;
      end
    end
    checks++;
    if (en_cnt != 1 || en_cyc != 1) begin
      failures++; $display("FAIL read_den: pulses=%0d cycle=%0d, want 1 pulse in cycle 1", en_cnt, en_cyc);
    end
    checks++;
    if (en_addr !== 7'h00 || en_we !== 1'b0) begin
      failures++; $display("FAIL read_den_fields: addr=%h we=%b, want 00/0", en_addr, en_we);
    end
    checks++;
    if (done_cyc != 5 || done_v !== 3'b001 || err_v !== 3'b000) begin
      failures++; $display("FAIL read_done: cycle=%0d done=%b err=%b, want 5/001/000", done_cyc, done_v, err_v);
    end
    checks++;
    if (rd !== 16'hB5E0) begin
      failures++; $display("FAIL read_rdata: got %h want b5e0", rd);
    end
    checks++;
    if (bus.rdata !== 16'hB5E0 || busy !== 1'b0) begin
      failures++; $display("FAIL read_hold: rdata=%h busy=%b, want b5e0/0", bus.rdata, busy);
    end
  endtask

  task automatic test_write();
    int en_cyc, done_cyc, my_lat;
    logic         en_we;
    logic [6:0]   en_addr;
    logic [15:0]  en_din;
    logic [N-1:0] done_v;
    my_lat = $urandom_range(1, 4);
    lat = my_lat;
    r_we[1] = 1'b1; r_addr[1] = 7'h51; r_wdata[1] = 16'h5999; r_en[1] = 1'b1;
    en_cyc = -1; done_cyc = -1; en_we = 1'b0; en_addr = 7'd0; en_din = 16'd0; done_v = '0;
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (drp_en === 1'b1 && en_cyc < 0) begin
        en_cyc = c; en_we = drp_we; en_addr = drp_addr; en_din = drp_din;
      end
      if (bus.req_done !== '0 && done_cyc < 0) begin
        done_cyc = c; done_v = bus.req_done; r_en[1] = 1'b0;
      end
    end
    ref_mem[7'h51] = 16'h5999;
    checks++;
    if (en_cyc != 1 || en_we !== 1'b1 || en_addr !== 7'h51 || en_din !== 16'h5999) begin
      failures++; $display("FAIL write_den: cycle=%0d we=%b addr=%h din=%h, want 1/1/51/5999",
                           en_cyc, en_we, en_addr, en_din);
    end
    checks++;
    if (done_cyc != my_lat + 2 || done_v !== 3'b010) begin
      failures++; $display("FAIL write_done: cycle=%0d done=%b, want %0d/010", done_cyc, done_v, my_lat + 2);
    end
    checks++;
    if (xmem[7'h51] !== 16'h5999) begin
      failures++; $display("FAIL write_mem: got %h want 5999", xmem[7'h51]);
    end
    checks++;
    if (drp_we !== 1'b1 || drp_addr !== 7'h51 || drp_din !== 16'h5999) begin
      failures++; $display("FAIL write_hold: we=%b addr=%h din=%h, want 1/51/5999", drp_we, drp_addr, drp_din);
    end
  endtask

  task automatic test_drdy_in_issue();
    int done_cyc;
    logic [6:0]   a;
    logic [15:0]  rd;
    logic [N-1:0] done_v;
    a = 7'($urandom_range(0, 127));
    lat = 0;
    r_we[2] = 1'b0; r_addr[2] = a; r_wdata[2] = 16'($urandom); r_en[2] = 1'b1;
    done_cyc = -1; rd = 16'd0; done_v = '0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (bus.req_done !== '0 && done_cyc < 0) begin
        done_cyc = c; done_v = bus.req_done; rd = bus.rdata; r_en[2] = 1'b0;
      end
    end
    checks++;
    if (done_cyc != 2 || done_v !== 3'b100) begin
      failures++; $display("FAIL issue_rdy_done: cycle=%0d done=%b, want 2/100", done_cyc, done_v);
    end
    checks++;
    if (rd !== ref_mem[a]) begin
      failures++; $display("FAIL issue_rdy_rdata: got %h want %h", rd, ref_mem[a]);
    end
  endtask

  task automatic test_contention();
    int last, ndone, ngrant, exp_w, w;
    int counts [N];
    int rearm  [N];
    logic [N-1:0] en_snap;
    do_reset();
    last = N - 1; ndone = 0; ngrant = 0; exp_w = 0;
    for (int i = 0; i < N; i++) begin
      counts[i] = 0; rearm[i] = 0;
      r_we[i] = 1'($urandom_range(0, 1)); r_addr[i] = 7'($urandom_range(0, 15));
      r_wdata[i] = 16'($urandom); r_en[i] = 1'b1;
    end
    for (int cyc = 0; cyc < 600 && ndone < 30; cyc++) begin
      en_snap = r_en;
      lat = $urandom_range(0, 5);
      tick();
      for (int i = 0; i < N; i++) begin
        if (rearm[i] > 0) begin
          rearm[i] = rearm[i] - 1;
          if (rearm[i] == 0) begin
            r_we[i] = 1'($urandom_range(0, 1)); r_addr[i] = 7'($urandom_range(0, 15));
            r_wdata[i] = 16'($urandom); r_en[i] = 1'b1;
          end
        end
      end
      if (drp_en === 1'b1) begin
        w = rr_pick(en_snap, last);
        if (w < 0) w = 0;
        exp_w = w; last = w; ngrant++;
        checks++;
        if (drp_we !== r_we[w] || drp_addr !== r_addr[w] || drp_din !== r_wdata[w]) begin
          failures++; $display("FAIL rr_grant: grant#%0d fields we=%b addr=%h din=%h, want requester %0d (%b/%h/%h)",
                               ngrant, drp_we, drp_addr, drp_din, w, r_we[w], r_addr[w], r_wdata[w]);
        end
      end
      if (bus.req_done !== '0) begin
        ndone++;
        checks++;
        if (bus.req_done !== oh(exp_w) || bus.req_err !== '0) begin
          failures++; $display("FAIL rr_done: done=%b err=%b, want %b/000", bus.req_done, bus.req_err, oh(exp_w));
        end
        if (r_we[exp_w]) begin
          ref_mem[r_addr[exp_w]] = r_wdata[exp_w];
        end else begin
          checks++;
          if (bus.rdata !== ref_mem[r_addr[exp_w]]) begin
            failures++; $display("FAIL rr_rdata: req %0d addr %h got %h want %h",
                                 exp_w, r_addr[exp_w], bus.rdata, ref_mem[r_addr[exp_w]]);
          end
        end
        counts[exp_w]++;
        r_en[exp_w]  = 1'b0;
        rearm[exp_w] = 2;
      end
    end
    r_en = '0;
    checks++;
    if (ndone != 30) begin
      failures++; $display("FAIL rr_budget: completions=%0d want 30 within cycle budget", ndone);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (counts[i] != 10) begin
        failures++; $display("FAIL rr_fair: requester %0d served %0d times, want 10", i, counts[i]);
      end
    end
    tick(); tick(); tick(); tick(); tick(); tick(); tick(); tick();
  endtask

  task automatic test_timeout();
    int done_cyc, err_seen, late_done;
    logic [N-1:0] done_v, err_v;
    logic [15:0]  rd;
    do_reset();
    mute = 1'b1;
    r_we[2] = 1'b0; r_addr[2] = 7'h03; r_wdata[2] = 16'($urandom); r_en[2] = 1'b1;
    done_cyc = -1; err_seen = 0; done_v = '0; err_v = '0; rd = 16'd0;
`ifdef XADC_DRP_TIMEOUT_EN
    for (int c = 1; c <= TO + 10 && done_cyc < 0; c++) begin
      tick();
      if (bus.req_done !== '0) begin
        done_cyc = c; done_v = bus.req_done; err_v = bus.req_err; rd = bus.rdata; r_en[2] = 1'b0;
      end
    end
    checks++;
    if (done_cyc != TO + 2 || done_v !== 3'b100 || err_v !== 3'b100) begin
      failures++; $display("FAIL timeout_done: cycle=%0d done=%b err=%b, want %0d/100/100",
                           done_cyc, done_v, err_v, TO + 2);
    end
    checks++;
    if (rd !== 16'hFFFF) begin
      failures++; $display("FAIL timeout_rdata: got %h want ffff", rd);
    end
    mute = 1'b0;
`else
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (bus.req_done !== '0) done_cyc = c;
      if (bus.req_err !== '0) err_seen++;
    end
    checks++;
    if (done_cyc >= 0 || busy !== 1'b1) begin
      failures++; $display("FAIL wait_forever: done at cycle %0d busy=%b, want none/1", done_cyc, busy);
    end
    checks++;
    if (err_seen != 0) begin
      failures++; $display("FAIL err_tied: req_err seen %0d times, want 0", err_seen);
    end
    do_reset();
    rd = bus.rdata;
`endif
    // Late DRDY while idle must not produce any completion.
    tick();
    rd = bus.rdata;
    inject_rdy = 1'b1;
    late_done  = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (bus.req_done !== '0 || bus.req_err !== '0) late_done++;
    end
    checks++;
    if (late_done != 0 || busy !== 1'b0 || bus.rdata !== rd) begin
      failures++; $display("FAIL late_drdy: pulses=%0d busy=%b rdata=%h, want 0/0/%h", late_done, busy, bus.rdata, rd);
    end
  endtask

  task automatic test_reset_mid();
    int done_cyc, early;
    logic [6:0]   a;
    logic [N-1:0] done_v;
    logic [15:0]  rd;
    do_reset();
    a = 7'($urandom_range(16, 127));
    lat = 6;
    r_we[0] = 1'b0; r_addr[0] = a; r_wdata[0] = 16'($urandom); r_en[0] = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL mid_busy: busy=%b want 1 before reset", busy);
    end
    rst_n = 1'b0;
    pend  = -1;
    #1;
    checks++;
    if ({bus.req_done, bus.req_err, bus.rdata, drp_en, drp_we, drp_addr, drp_din, busy} !== '0) begin
      failures++; $display("FAIL mid_reset_async: done=%b err=%b rdata=%h en=%b addr=%h busy=%b, want all 0",
                           bus.req_done, bus.req_err, bus.rdata, drp_en, drp_addr, busy);
    end
    tick();
    checks++;
    if (bus.req_done !== '0 || busy !== 1'b0) begin
      failures++; $display("FAIL mid_reset_hold: done=%b busy=%b, want 000/0", bus.req_done, busy);
    end
    rst_n = 1'b1;
    lat = 2;
    done_cyc = -1; early = 0; done_v = '0; rd = 16'd0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (bus.req_done !== '0 && done_cyc < 0) begin
        done_cyc = c; done_v = bus.req_done; rd = bus.rdata; r_en[0] = 1'b0;
      end
    end
    checks++;
    if (done_cyc != 4 || done_v !== 3'b001 || rd !== ref_mem[a]) begin
      failures++; $display("FAIL mid_recover: cycle=%0d done=%b rdata=%h, want 4/001/%h",
                           done_cyc, done_v, rd, ref_mem[a]);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write();
    test_drdy_in_issue();
    test_contention();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
